// File: rtl/mprj_io_seq_checker.sv
// Samples a user IO bus and walks a programmable table of masked patterns,
// each of which must hold for STABLE cycles before a per-step timeout.
module mprj_io_seq_checker #(
   parameter int  WIDTH   = 8,
   parameter int  DEPTH   = 4,
   parameter int  TIMEOUT = 25000,
   parameter int  STABLE  = 2,
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic [WIDTH-1:0] io_in,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [WIDTH-1:0] cfg_pattern,
   input  logic [WIDTH-1:0] cfg_mask,
   input  logic [AW:0]      seq_len,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic [AW-1:0]    step,
   output logic [AW-1:0]    fail_step
);

   localparam int            TW         = $clog2(TIMEOUT);
   localparam int            SW         = $clog2(STABLE + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE - 1);
   localparam logic [AW:0]   LEN_MAX    = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   LEN_ONE    = (AW + 1)'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE_PASS, DONE_FAIL} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] pattern_q [DEPTH];
   logic [WIDTH-1:0] mask_q    [DEPTH];
   logic [AW:0]      len_q;
   logic [TW-1:0]    timer_q;
   logic [SW-1:0]    stab_q;

   logic [AW:0] len_start;
   logic        match;
   logic        step_done;
   logic        last_step;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= io_in;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         // NOTE: the table is deliberately reset; an all-zero mask is the match-anything default.
         for (int i = 0; i < DEPTH; i++) begin
            pattern_q[i] <= '0;
            mask_q[i]    <= '0;
         end
      end else if (cfg_we && !busy && ({1'b0, cfg_addr} < LEN_MAX)) begin
         pattern_q[cfg_addr] <= cfg_pattern;
         mask_q[cfg_addr]    <= cfg_mask;
      end
   end

   assign len_start = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
   assign match     = ((sync2_q ^ pattern_q[step]) & mask_q[step]) == '0;
   assign step_done = match && (stab_q == STAB_LAST);
   assign last_step = ({1'b0, step} == (len_q - LEN_ONE));

   // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q   <= IDLE;
         busy      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         step      <= '0;
         fail_step <= '0;
         len_q     <= '0;
         timer_q   <= '0;
         stab_q    <= '0;
      end else if (abort) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         pass    <= 1'b0;
         fail    <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               // Completion is tested first so it beats a timeout landing on the same cycle.
               if (step_done) begin
                  stab_q  <= '0;
                  timer_q <= '0;
                  if (last_step) begin
                     state_q <= DONE_PASS;
                     busy    <= 1'b0;
                     pass    <= 1'b1;
                  end else begin
                     step <= step + AW'(1);
                  end
               end else if (timer_q == TIMER_LAST) begin
                  state_q   <= DONE_FAIL;
                  busy      <= 1'b0;
                  fail      <= 1'b1;
                  fail_step <= step;
               end else begin
                  timer_q <= timer_q + TW'(1);
                  stab_q  <= match ? stab_q + SW'(1) : '0;
               end
            end
            default: begin
               if (start) begin
                  len_q   <= len_start;
                  step    <= '0;
                  timer_q <= '0;
                  stab_q  <= '0;
                  fail    <= 1'b0;
                  if (len_start == '0) begin
                     state_q <= DONE_PASS;
                     busy    <= 1'b0;
                     pass    <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     busy    <= 1'b1;
                     pass    <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mprj_io_seq_checker.sv
// Bench for mprj_io_seq_checker: two instances (STABLE=2 and STABLE=3, TIMEOUT=50)
// share stimulus; per-cycle expectations are queued when driven and popped after the edge.
module tb_mprj_io_seq_checker;

   localparam logic [2:0] S_I = 3'b000;  // {busy, pass, fail}
   localparam logic [2:0] S_R = 3'b100;
   localparam logic [2:0] S_P = 3'b010;
   localparam logic [2:0] S_F = 3'b001;

   typedef struct {
      string      tag;
      logic       start;
      logic       abort;
      logic [2:0] len;
      logic [7:0] io;
      logic       we;
      logic [1:0] addr;
      logic [7:0] pat;
      logic [7:0] msk;
      logic       chk;
      logic [2:0] ea;
      logic [1:0] sa;
      logic [2:0] eb;
      logic [1:0] sb;
      logic [1:0] fstep;
   } vec_t;

   logic       clock;
   logic       resetb;
   logic [7:0] io_in;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_pattern;
   logic [7:0] cfg_mask;
   logic [2:0] seq_len;
   logic       start;
   logic       abort;
   logic       a_busy, a_pass, a_fail, b_busy, b_pass, b_fail;
   logic [1:0] a_step, a_fstep, b_step, b_fstep;

   int   total = 0;
   int   bad   = 0;
   vec_t exp_q[$];
   vec_t cur;
   vec_t t1 [12];
   vec_t v;

   mprj_io_seq_checker #(.WIDTH(8), .DEPTH(4), .TIMEOUT(50), .STABLE(2)) dut_a (
      .clock(clock), .resetb(resetb), .io_in(io_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .seq_len(seq_len), .start(start),
      .abort(abort), .busy(a_busy), .pass(a_pass), .fail(a_fail), .step(a_step),
      .fail_step(a_fstep));

   mprj_io_seq_checker #(.WIDTH(8), .DEPTH(4), .TIMEOUT(50), .STABLE(3)) dut_b (
      .clock(clock), .resetb(resetb), .io_in(io_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .seq_len(seq_len), .start(start),
      .abort(abort), .busy(b_busy), .pass(b_pass), .fail(b_fail), .step(b_step),
      .fail_step(b_fstep));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input string tag, input logic st, input logic ab,
                                input logic [2:0] ln, input logic [7:0] io,
                                input logic [2:0] ea, input logic [1:0] sa,
                                input logic [2:0] eb, input logic [1:0] sb);
      vec_t r;
      r.tag = tag;  r.start = st; r.abort = ab; r.len = ln; r.io = io;
      r.we  = 1'b0; r.addr = '0;  r.pat = '0;   r.msk = '0;
      r.chk = 1'b1; r.ea = ea; r.sa = sa; r.eb = eb; r.sb = sb; r.fstep = 2'd1;
      return r;
   endfunction

   function automatic vec_t with_wr(input vec_t r, input logic [1:0] addr,
                                    input logic [7:0] pat, input logic [7:0] msk);
      vec_t o = r;
      o.we = 1'b1; o.addr = addr; o.pat = pat; o.msk = msk;
      return o;
   endfunction

   task automatic drive(input vec_t r);
      @(negedge clock);
      start       = r.start;
      abort       = r.abort;
      seq_len     = r.len;
      io_in       = r.io;
      cfg_we      = r.we;
      cfg_addr    = r.addr;
      cfg_pattern = r.pat;
      cfg_mask    = r.msk;
      exp_q.push_back(r);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_a_bpf"}, {a_busy, a_pass, a_fail}, S_I);
      check({tag, "_a_step"}, a_step, 2'd0);
      check({tag, "_a_fstep"}, a_fstep, 2'd0);
      check({tag, "_b_bpf"}, {b_busy, b_pass, b_fail}, S_I);
      check({tag, "_b_step"}, b_step, 2'd0);
      check({tag, "_b_fstep"}, b_fstep, 2'd0);
   endtask

   // Scoreboard: each queued row describes the outputs expected after the next rising edge.
   always @(posedge clock) begin
      #1;
      if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         if (cur.chk) begin
            check({cur.tag, "_a_bpf"}, {a_busy, a_pass, a_fail}, cur.ea);
            check({cur.tag, "_a_step"}, a_step, cur.sa);
            if (cur.ea[0]) check({cur.tag, "_a_fstep"}, a_fstep, cur.fstep);
            check({cur.tag, "_b_bpf"}, {b_busy, b_pass, b_fail}, cur.eb);
            check({cur.tag, "_b_step"}, b_step, cur.sb);
            if (cur.eb[0]) check({cur.tag, "_b_fstep"}, b_fstep, cur.fstep);
         end
      end
   end

   initial begin
      // Zero table: control races and the minimum pass time.
      t1[0]  = mkv("len1_start",   1, 0, 3'd1, 8'h00, S_R, 2'd0, S_R, 2'd0);
      t1[1]  = mkv("len1_run",     0, 0, 3'd1, 8'h00, S_R, 2'd0, S_R, 2'd0);
      t1[2]  = mkv("len1_pass",    0, 0, 3'd1, 8'h00, S_P, 2'd0, S_R, 2'd0);
      t1[3]  = mkv("len1_hold",    0, 0, 3'd1, 8'h00, S_P, 2'd0, S_P, 2'd0);
      t1[4]  = mkv("abort",        0, 1, 3'd1, 8'h00, S_I, 2'd0, S_I, 2'd0);
      t1[5]  = mkv("len0_pass",    1, 0, 3'd0, 8'h00, S_P, 2'd0, S_P, 2'd0);
      t1[6]  = mkv("abort_start",  1, 1, 3'd1, 8'h00, S_I, 2'd0, S_I, 2'd0);
      t1[7]  = mkv("restart",      1, 0, 3'd1, 8'h00, S_R, 2'd0, S_R, 2'd0);
      t1[8]  = mkv("start_in_run", 1, 0, 3'd1, 8'h00, S_R, 2'd0, S_R, 2'd0);
      t1[9]  = mkv("run_pass_a",   0, 0, 3'd1, 8'h00, S_P, 2'd0, S_R, 2'd0);
      t1[10] = mkv("run_pass_b",   0, 0, 3'd1, 8'h00, S_P, 2'd0, S_P, 2'd0);
      t1[11] = mkv("abort2",       0, 1, 3'd1, 8'h00, S_I, 2'd0, S_I, 2'd0);

      resetb = 1'b0; io_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_pattern = '0;
      cfg_mask = '0; seq_len = '0; start = 1'b0; abort = 1'b0;
      #12;
      check_zero("reset_init");
      @(negedge clock);
      resetb = 1'b1;

      for (int i = 0; i < 12; i++) drive(t1[i]);

      // seq_len=7 clamps to 4 steps.
      for (int k = 0; k <= 12; k++)
         drive(mkv($sformatf("clamp_k%0d", k), k == 0, 0, 3'd7, 8'h00,
                   (k >= 8) ? S_P : S_R, (k >= 8) ? 2'd3 : 2'(k / 2),
                   (k >= 12) ? S_P : S_R, (k >= 12) ? 2'd3 : 2'(k / 3)));

      // Program the table while idle.
      drive(with_wr(mkv("wr0", 0, 0, 3'd0, 8'h00, S_P, 2'd3, S_P, 2'd3), 2'd0, 8'h01, 8'hFF));
      drive(with_wr(mkv("wr1", 0, 0, 3'd0, 8'h00, S_P, 2'd3, S_P, 2'd3), 2'd1, 8'h02, 8'hFF));
      drive(with_wr(mkv("wr2", 0, 0, 3'd0, 8'h00, S_P, 2'd3, S_P, 2'd3), 2'd2, 8'h80, 8'h80));

      // Three-step sequence with io 0x01, 0x02, 0xC3 held 10 cycles each.
      for (int k = 0; k < 30; k++)
         drive(mkv($sformatf("seq_k%0d", k), k == 0, 0, 3'd3,
                   (k < 10) ? 8'h01 : (k < 20) ? 8'h02 : 8'hC3,
                   (k >= 23) ? S_P : S_R, (k < 3) ? 2'd0 : (k < 13) ? 2'd1 : 2'd2,
                   (k >= 24) ? S_P : S_R, (k < 4) ? 2'd0 : (k < 14) ? 2'd1 : 2'd2));

      // Stability: a one-cycle glitch restarts the count; abort holds step.
      drive(mkv("stab_abort", 0, 1, 3'd1, 8'h00, S_I, 2'd2, S_I, 2'd2));
      for (int k = 0; k <= 10; k++)
         drive(mkv($sformatf("stab_k%0d", k), k == 0, 0, 3'd1,
                   (k == 1 || k == 2 || k >= 4) ? 8'h01 : 8'h00,
                   (k >= 4) ? S_P : S_R, 2'd0, (k >= 8) ? S_P : S_R, 2'd0));

      // Timeout: step 1 (0x02) never matches.
      for (int k = 0; k <= 53; k++)
         drive(mkv($sformatf("tmo_k%0d", k), k == 0, 0, 3'd2, 8'h01,
                   (k >= 52) ? S_F : S_R, (k < 2) ? 2'd0 : 2'd1,
                   (k >= 53) ? S_F : S_R, (k < 3) ? 2'd0 : 2'd1));

      // Completion on the last timer cycle wins over the timeout.
      for (int k = 0; k <= 54; k++)
         drive(mkv($sformatf("edge_k%0d", k), k == 0, 0, 3'd2, (k >= 49) ? 8'h02 : 8'h01,
                   (k >= 52) ? S_P : S_R, (k < 2) ? 2'd0 : 2'd1,
                   (k >= 53) ? S_P : S_R, (k < 3) ? 2'd0 : 2'd1));

      // Table write while busy is ignored; the rerun still matches entry 0.
      for (int k = 0; k <= 7; k++) begin
         v = mkv($sformatf("wrbusy_k%0d", k), k == 0 || k == 4, 0, 3'd1, 8'h01,
                 (k == 3 || k >= 6) ? S_P : S_R, 2'd0, (k >= 4) ? S_P : S_R, 2'd0);
         if (k == 1) v = with_wr(v, 2'd0, 8'h55, 8'hFF);
         drive(v);
      end

      // Reach step 1, then reset asynchronously between edges.
      for (int k = 0; k <= 3; k++)
         drive(mkv($sformatf("prerst_k%0d", k), k == 0, 0, 3'd2, 8'h01,
                   S_R, (k < 2) ? 2'd0 : 2'd1, S_R, (k < 3) ? 2'd0 : 2'd1));
      @(negedge clock);
      #2 resetb = 1'b0;
      #1 check_zero("reset_async");
      @(negedge clock);
      resetb = 1'b1;

      // Cleared table matches anything: len=1 passes after STABLE cycles.
      for (int k = 0; k <= 3; k++)
         drive(mkv($sformatf("postrst_k%0d", k), k == 0, 0, 3'd1, 8'h00,
                   (k >= 2) ? S_P : S_R, 2'd0, (k >= 3) ? S_P : S_R, 2'd0));

      v = mkv("idle", 0, 0, 3'd0, 8'h00, S_I, 2'd0, S_I, 2'd0);
      v.chk = 1'b0;
      drive(v);
      @(posedge clock);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
